// File: rtl/trace_readout_if.sv
// trace_readout_if -- bundles the signals of the trace readout engine.
//
// Handshake rules:
//   start/abort : level-sampled control inputs. start is acted on only while
//                 busy=0. abort cancels a dump in any busy state.
//   tb_rd_en    : one-cycle read strobe to the trace buffer. The buffer returns
//                 tb_dout on the following cycle. No back-pressure.
//   tdo_valid /
//   shift_en    : valid/ready pair for the serial stream. One bit moves on
//                 every rising edge where tdo_valid && shift_en. While
//                 shift_en=0, tdo and frame hold their values. A bit whose
//                 cycle also carries abort or reset is not transferred.
//
// Modports:
//   master : the readout engine. Drives the buffer read strobe, the serial
//            stream and the status outputs.
//   slave  : the environment. Drives the controls, the buffer data and
//            shift_en.
//   fsm_state is a debug copy of the engine's state register.
interface trace_readout_if #(
    parameter int Fpay = 32,
    parameter int Aw   = 9
);
    logic            start;
    logic            abort;
    logic [Aw:0]     tb_level;
    logic            tb_rd_en;
    logic [Fpay-1:0] tb_dout;
    logic            shift_en;
    logic            tdo;
    logic            tdo_valid;
    logic            frame;
    logic            busy;
    logic            done;
    logic [Aw:0]     words_sent;
    logic [2:0]      fsm_state;

    modport master (
        input  start, abort, tb_level, tb_dout, shift_en,
        output tb_rd_en, tdo, tdo_valid, frame, busy, done, words_sent, fsm_state
    );

    modport slave (
        output start, abort, tb_level, tb_dout, shift_en,
        input  tb_rd_en, tdo, tdo_valid, frame, busy, done, words_sent, fsm_state
    );
endinterface

// File: rtl/trace_readout.sv
// trace_readout -- dumps the contents of a trace buffer as an LSB-first serial
// stream.
//
// When start is seen in IDLE, the engine latches tb_level as the word count N.
// For each word it then:
//   - issues one tb_rd_en (RD),
//   - captures tb_dout (CAP),
//   - shifts the Fpay bits out on tdo under shift_en control (SHIFT).
// After the last word it pulses done (FIN) and returns to IDLE.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : trace_readout_if.master. Carries start, abort, tb_level,
//           tb_rd_en, tb_dout, shift_en, tdo, tdo_valid, frame, busy, done,
//           words_sent, plus fsm_state for debug.
module trace_readout #(
    parameter int Fpay = 32,
    parameter int Aw   = 9
) (
    input  logic             clk,
    input  logic             reset,
    trace_readout_if.master  bus
);
    localparam int              BW       = (Fpay > 1) ? $clog2(Fpay) : 1;
    localparam logic [BW-1:0]   LAST_BIT = BW'(Fpay - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        CAP   = 3'd2,
        SHIFT = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [Fpay-1:0] shift_reg, shift_nxt;
    logic [BW-1:0]   bit_cnt, bit_nxt;
    logic [Aw:0]     words_sent, words_nxt;
    logic [Aw:0]     n_words, n_nxt;
    // An empty dump spends two cycles in FIN so that done lands two cycles
    // after start. done is withheld during the first of those cycles.
    logic            empty_wait, empty_nxt;
    logic [Aw:0]     words_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            words_sent <= '0;
            n_words    <= '0;
            empty_wait <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            bit_cnt    <= bit_nxt;
            words_sent <= words_nxt;
            n_words    <= n_nxt;
            empty_wait <= empty_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        bit_nxt   = bit_cnt;
        words_nxt = words_sent;
        n_nxt     = n_words;
        empty_nxt = empty_wait;
        // Aw+1 bits hold N up to 2**Aw, so this increment cannot wrap.
        words_inc = words_sent + 1'b1;

        if (state != IDLE && bus.abort) begin
            // abort beats shift_en. words_sent keeps the completed-word count.
            state_nxt = IDLE;
            empty_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_nxt     = bus.tb_level;
                        words_nxt = '0;
                        if (bus.tb_level == '0) begin
                            state_nxt = FIN;
                            empty_nxt = 1'b1;
                        end else begin
                            state_nxt = RD;
                        end
                    end
                end
                RD: begin
                    state_nxt = CAP;
                end
                CAP: begin
                    shift_nxt = bus.tb_dout;
                    bit_nxt   = '0;
                    state_nxt = SHIFT;
                end
                SHIFT: begin
                    if (bus.shift_en) begin
                        shift_nxt = shift_reg >> 1;
                        bit_nxt   = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            words_nxt = words_inc;
                            state_nxt = (words_inc < n_words) ? RD : FIN;
                        end
                    end
                end
                FIN: begin
                    if (empty_wait) begin
                        empty_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.tb_rd_en   = (state == RD);
    assign bus.tdo_valid  = (state == SHIFT);
    assign bus.tdo        = (state == SHIFT) & shift_reg[0];
    assign bus.frame      = (state == SHIFT) && (bit_cnt == '0);
    assign bus.busy       = (state != IDLE);
    // An abort arriving in FIN suppresses the completion pulse.
    assign bus.done       = (state == FIN) && !empty_wait && !bus.abort;
    assign bus.words_sent = words_sent;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_trace_readout.sv
// tb_trace_readout -- self-checking bench for trace_readout.
//
// A small buffer model answers tb_rd_en with the next stored word one cycle
// later. Each dump builds the expected word list (exp_q) from the buffer
// contents. The serial stream is then checked bit by bit: bit k of the dump
// must equal bit (k mod Fpay) of word (k div Fpay). Timing rules are checked
// from cycle stamps taken while the dump runs.
module tb_trace_readout;
    localparam int Fpay  = 32;
    localparam int Aw    = 3;
    localparam int Depth = 1 << Aw;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trace_readout_if #(.Fpay(Fpay), .Aw(Aw)) bus ();

    trace_readout #(.Fpay(Fpay), .Aw(Aw)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int              total = 0;
    int              bad   = 0;
    string           cur_name = "init";
    logic [Fpay-1:0] mem [Depth];
    logic [Fpay-1:0] exp_q [$];
    int rd_ptr, cyc, rd_cnt, done_cnt, done_cyc, busy_cnt, valid_cnt;
    int first_valid, last_valid, bit_idx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s: observed=%0d expected=%0d", cur_name, tag, obs, exp);
        end
    endtask

    // Observe the current cycle, then advance one clock and serve buffer reads.
    task automatic step();
        logic            rd_seen;
        logic [Fpay-1:0] w;
        rd_seen = bus.tb_rd_en;
        if (bus.tb_rd_en === 1'b1) rd_cnt++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.tdo_valid === 1'b1) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
            else if (last_valid != cyc - 1) check("word_gap", cyc - last_valid - 1, 2);
            last_valid = cyc;
            if (bit_idx / Fpay < exp_q.size()) begin
                w = exp_q[bit_idx / Fpay];
                check("tdo", bus.tdo, w[bit_idx % Fpay]);
            end else begin
                check("bit_overrun", bit_idx, exp_q.size() * Fpay);
            end
            check("frame", bus.frame, (bit_idx % Fpay) == 0);
            if (bus.shift_en && !bus.abort && !rst) bit_idx++;
        end else begin
            check("frame_idle", bus.frame, 0);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rd_seen === 1'b1) begin
            bus.tb_dout = (rd_ptr < Depth) ? mem[rd_ptr] : '0;
            rd_ptr++;
        end
    endtask

    task automatic idle(input int n);
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.shift_en = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fill_random();
        for (int i = 0; i < Depth; i++) mem[i] = $urandom;
    endtask

    // pat: 0 = shift_en held high, 1 = toggling 1-0-1-0, 2 = random.
    // abort_at / reset_at: number of accepted bits at which to fire (-1 = never).
    // restart_at: cycle offset at which a second start is attempted (-1 = never).
    task automatic run_dump(input string name, input int level, input int pat,
                            input int abort_at, input int reset_at, input int restart_at);
        int          start_cyc, n_cyc, tmp;
        bit          stop;
        logic [Aw:0] lv;
        cur_name = name;
        exp_q.delete();
        for (int i = 0; i < level; i++) exp_q.push_back(mem[i]);
        rd_ptr = 0; rd_cnt = 0; done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
        first_valid = -1; last_valid = -1; bit_idx = 0; done_cyc = -1;

        lv = level[Aw:0];
        bus.tb_level = lv;
        bus.start    = 1'b1;
        bus.abort    = ($urandom_range(0, 1) == 1);   // start must win in IDLE
        bus.shift_en = 1'b0;
        start_cyc    = cyc;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tmp = $urandom;
        bus.tb_level = tmp[Aw:0];                      // must not affect N

        stop  = 1'b0;
        n_cyc = 0;
        while (!stop && n_cyc < 3000) begin
            case (pat)
                0:       bus.shift_en = 1'b1;
                1:       bus.shift_en = (n_cyc % 2 == 0);
                default: bus.shift_en = ($urandom_range(0, 3) != 0);
            endcase
            bus.abort = (abort_at >= 0) && (bit_idx == abort_at) && (bus.tdo_valid === 1'b1);
            if (bus.abort) bus.shift_en = 1'b1;
            rst = (reset_at >= 0) && (bit_idx == reset_at) && (bus.tdo_valid === 1'b1);
            if (rst) bus.shift_en = 1'b1;
            bus.start = (n_cyc == restart_at);
            if (bus.start) begin
                tmp = $urandom_range(1, Depth);
                bus.tb_level = tmp[Aw:0];
            end
            stop = bus.abort || rst || (bus.done === 1'b1);
            step();
            n_cyc++;
        end
        rst = 1'b0;
        check("finished_in_budget", stop, 1);

        if (abort_at >= 0) begin
            check("abort_busy", bus.busy, 0);
            check("abort_tdo_valid", bus.tdo_valid, 0);
            idle(4);
            check("abort_no_done", done_cnt, 0);
            check("abort_words_sent", bus.words_sent, abort_at / Fpay);
            check("abort_rd_count", rd_cnt, abort_at / Fpay + 1);
        end else if (reset_at >= 0) begin
            check("rst_tb_rd_en", bus.tb_rd_en, 0);
            check("rst_tdo", bus.tdo, 0);
            check("rst_tdo_valid", bus.tdo_valid, 0);
            check("rst_frame", bus.frame, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
            check("rst_words_sent", bus.words_sent, 0);
            idle(4);
            check("rst_no_done", done_cnt, 0);
        end else begin
            check("busy_after_done", bus.busy, 0);
            idle(4);
            check("done_count", done_cnt, 1);
            check("rd_count", rd_cnt, level);
            check("words_sent", bus.words_sent, level);
            check("bits_sent", bit_idx, level * Fpay);
            if (level == 0) begin
                check("empty_done_latency", done_cyc - start_cyc, 2);
                check("empty_busy_cycles", busy_cnt, 2);
            end else begin
                check("first_valid_latency", first_valid - start_cyc, 3);
                // Busy covers RD+CAP per word, every SHIFT cycle, and FIN.
                check("busy_cycles", busy_cnt, valid_cnt + 2 * level + 1);
            end
        end
    endtask

    initial begin
        int lvl;
        cyc          = 0;
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        bus.shift_en = 1'b1;
        bus.tb_level = 4'd3;
        bus.tb_dout  = '0;
        repeat (2) @(posedge clk);
        #1;
        cur_name = "reset";
        check("tb_rd_en", bus.tb_rd_en, 0);
        check("tdo", bus.tdo, 0);
        check("tdo_valid", bus.tdo_valid, 0);
        check("frame", bus.frame, 0);
        check("busy", bus.busy, 0);
        check("done", bus.done, 0);
        check("words_sent", bus.words_sent, 0);
        rst = 1'b0;
        idle(2);
        check("busy_after_release", bus.busy, 0);

        mem[0] = 32'hA5A5_0001;
        mem[1] = 32'h0000_FFFF;
        run_dump("two_words", 2, 0, -1, -1, -1);

        run_dump("empty", 0, 0, -1, -1, -1);

        fill_random();
        run_dump("toggle_shift", $urandom_range(1, 4), 1, -1, -1, -1);

        fill_random();
        run_dump("abort_40", 3, 0, 40, -1, -1);
        fill_random();
        run_dump("after_abort", 1, 0, -1, -1, -1);

        fill_random();
        run_dump("abort_last_bit", 1, 0, 31, -1, -1);

        fill_random();
        run_dump("reset_mid", 3, 0, -1, 40, -1);
        fill_random();
        run_dump("restart_ignored", 2, 2, -1, -1, 5);

        fill_random();
        run_dump("full_buffer", Depth, 0, -1, -1, -1);

        for (int i = 0; i < 4; i++) begin
            fill_random();
            lvl = $urandom_range(0, Depth);
            run_dump("random", lvl, $urandom_range(0, 2), -1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trace_readout.md
TRACE_READOUT -- requirements
Module: trace_readout

Interface
REQ-001 SHALL have parameter Fpay, default 32: trace word width in bits.
REQ-002 SHALL have parameter Aw, default 9: trace buffer address width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to dump the buffer.
REQ-006 SHALL have port abort, input, 1: cancel the dump in progress.
REQ-007 SHALL have port tb_level, input, Aw+1: number of valid words held in the trace buffer.
REQ-008 SHALL have port tb_rd_en, output, 1: read strobe to the trace buffer.
REQ-009 SHALL have port tb_dout, input, Fpay: trace buffer read data, valid the cycle after tb_rd_en.
REQ-010 SHALL have port shift_en, input, 1: host accepts one serial bit this cycle.
REQ-011 SHALL have port tdo, output, 1: serial trace data, LSB first.
REQ-012 SHALL have port tdo_valid, output, 1: tdo holds a valid bit.
REQ-013 SHALL have port frame, output, 1: tdo is bit 0 of a word.
REQ-014 SHALL have port busy, output, 1: a dump is in progress.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when a dump completes normally.
REQ-016 SHALL have port words_sent, output, Aw+1: number of words fully shifted out in the current or last dump.

Function
REQ-017 SHALL implement FSM states IDLE, RD, CAP, SHIFT, FIN.
REQ-018 In IDLE, start with tb_level!=0 SHALL latch N=tb_level, clear words_sent, and go to RD.
REQ-019 In IDLE, start with tb_level==0 SHALL go to FIN without any tb_rd_en, so done pulses exactly 2 cycles after start.
REQ-020 RD SHALL assert tb_rd_en for exactly one cycle, then go to CAP.
REQ-021 CAP SHALL load tb_dout into a Fpay-bit shift register, clear the bit counter, then go to SHIFT.
REQ-022 In SHIFT, tdo_valid=1, tdo=shift_reg[0], and frame=1 only while the bit counter is 0.
REQ-023 In SHIFT, a transfer SHALL occur when shift_en&&tdo_valid; it shifts the register right by one and increments the bit counter.
REQ-024 Without shift_en, tdo and the bit counter SHALL hold indefinitely.
REQ-025 The transfer of bit Fpay-1 SHALL increment words_sent and go to RD if words_sent+1<N, otherwise to FIN.
REQ-026 FIN SHALL assert done for one cycle and go to IDLE; words_sent holds its value until the next accepted start.
REQ-027 busy SHALL be 1 in RD, CAP, SHIFT and FIN, and 0 in IDLE.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 tb_level changes after the start cycle SHALL NOT affect N.
REQ-030 tb_rd_en SHALL be asserted exactly N times per dump, never in IDLE or FIN.
REQ-031 abort in any non-IDLE state SHALL return the FSM to IDLE next cycle with no done pulse and tdo_valid=0.
REQ-032 On abort, words_sent SHALL keep its count of completed words.
REQ-033 abort SHALL take priority over shift_en in the same cycle; the bit is not counted.
REQ-034 abort and start together in IDLE: start SHALL win and abort SHALL be ignored.
REQ-035 N=2^Aw (full buffer) SHALL be supported without counter overflow; words_sent is Aw+1 bits wide.
REQ-036 Latency from start to the first tdo_valid SHALL be 3 cycles: IDLE->RD->CAP->SHIFT.
REQ-037 There SHALL be a 2-cycle tdo_valid gap (RD, CAP) between consecutive words.

Reset
REQ-038 reset SHALL force IDLE with tb_rd_en=0, tdo=0, tdo_valid=0, frame=0, busy=0, done=0, words_sent=0, shift register=0, bit counter=0, and N=0.
REQ-039 reset asserted mid-dump SHALL abandon the dump with no done pulse; the next start begins a fresh dump.
REQ-040 reset SHALL override start, abort and shift_en in the same cycle.

Verification
REQ-041 tb_level=2, words 0xA5A5_0001 then 0x0000_FFFF, shift_en held 1, start pulse -> tdo_valid rises 3 cycles after start, 64 bits LSB first, frame at bit 0 of each word, 2-cycle gap between words, done once, words_sent=2.
REQ-042 start with tb_level=0 -> no tb_rd_en, done 2 cycles after start, words_sent=0, busy high for 2 cycles.
REQ-043 shift_en toggled 1-0-1-0 during a word -> exactly 32 transfers per word, tdo stable while shift_en=0, tb_rd_en count equals tb_level.
REQ-044 tb_level=3, abort after 40 accepted bits -> IDLE next cycle, no done, words_sent=1; a following start with tb_level=1 -> 32 bits, done, words_sent=1.
REQ-045 reset pulse during SHIFT of word 2 -> all outputs at reset values next cycle; start ignored while busy, verified by a second start 5 cycles into a dump having no effect.
REQ-046 Aw=3, tb_level=8 -> 8 reads, words_sent=8 with no wrap, done once.
